// File: rtl/fifo_fwft_v2.sv
// First-word-fall-through synchronous FIFO: RAM array -> middle register -> dout register, exact occupancy count.
// Optional sticky overflow/underflow outputs when FIFO_FWFT_ERR_EN is defined.
module fifo_fwft_v2 #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 4,
    parameter int AF_THRESH   = (1 << DEPTH_WIDTH) - 1,
    parameter int AE_THRESH   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   almost_full,
    output logic [DATA_WIDTH-1:0]  dout,
    input  logic                   rd_en,
    output logic                   empty,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   cnt
`ifdef FIFO_FWFT_ERR_EN
    ,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_WIDTH:0]   arr_cnt_reg, arr_cnt_next;
    logic [DEPTH_WIDTH:0]   cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0]  mid_reg;
    logic                   mid_valid_reg, mid_valid_next;
    logic [DATA_WIDTH-1:0]  dout_reg, dout_next;
    logic                   dout_valid_reg, dout_valid_next;
    logic                   wr_acc, rd_acc, dout_load, fetch;

    // Full is judged on the registered count, so a pop in the same cycle cannot make room for a write.
    assign full         = (cnt_reg == (DEPTH_WIDTH+1)'(DEPTH));
    assign almost_full  = (int'(cnt_reg) >= AF_THRESH);
    assign almost_empty = (int'(cnt_reg) <= AE_THRESH);
    assign empty        = !dout_valid_reg;
    assign dout         = dout_reg;
    assign cnt          = cnt_reg;

    assign wr_acc    = wr_en && !full;
    assign rd_acc    = rd_en && dout_valid_reg;
    assign dout_load = mid_valid_reg && (!dout_valid_reg || rd_acc);
    // The array is refilled into the middle stage in the same cycle the middle stage drains, so no bubbles.
    assign fetch     = (arr_cnt_reg != '0) && (!mid_valid_reg || dout_load);

    always_comb begin
        wr_ptr_next     = wr_ptr_reg + DEPTH_WIDTH'(wr_acc);
        rd_ptr_next     = rd_ptr_reg + DEPTH_WIDTH'(fetch);
        arr_cnt_next    = arr_cnt_reg + (DEPTH_WIDTH+1)'(wr_acc) - (DEPTH_WIDTH+1)'(fetch);
        cnt_next        = cnt_reg + (DEPTH_WIDTH+1)'(wr_acc) - (DEPTH_WIDTH+1)'(rd_acc);
        mid_valid_next  = fetch ? 1'b1 : (dout_load ? 1'b0 : mid_valid_reg);
        dout_valid_next = dout_load ? 1'b1 : (rd_acc ? 1'b0 : dout_valid_reg);
        dout_next       = dout_load ? mid_reg : dout_reg;
        if (clr) begin
            wr_ptr_next     = '0;
            rd_ptr_next     = '0;
            arr_cnt_next    = '0;
            cnt_next        = '0;
            mid_valid_next  = 1'b0;
            dout_valid_next = 1'b0;
            dout_next       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !clr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            arr_cnt_reg    <= '0;
            cnt_reg        <= '0;
            mid_reg        <= '0;
            mid_valid_reg  <= 1'b0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            arr_cnt_reg    <= arr_cnt_next;
            cnt_reg        <= cnt_next;
            mid_valid_reg  <= mid_valid_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            if (fetch && !clr) begin
                mid_reg <= mem[rd_ptr_reg];
            end
        end
    end

`ifdef FIFO_FWFT_ERR_EN
    logic overflow_reg, underflow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clr) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= overflow_reg  || (wr_en && full);
            underflow_reg <= underflow_reg || (rd_en && !dout_valid_reg);
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_fifo_fwft_v2.sv
// Directed bench for fifo_fwft_v2 (DEPTH_WIDTH=3) checked every cycle against a queue model of the FIFO.
module tb_fifo_fwft_v2;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 7;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          full, almost_full, empty, almost_empty;
    logic [DW-1:0] dout;
    logic [AW:0]   cnt;
`ifdef FIFO_FWFT_ERR_EN
    logic          overflow, underflow;
`endif

    fifo_fwft_v2 #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .wr_en(wr_en),
        .full(full), .almost_full(almost_full), .dout(dout), .rd_en(rd_en),
        .empty(empty), .almost_empty(almost_empty), .cnt(cnt)
`ifdef FIFO_FWFT_ERR_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: accepted words in order, each stamped with the edge index at which it was written.
    // A head word is presented once two edges have completed since its write.
    typedef struct {
        logic [DW-1:0] d;
        int            e;
    } ent_t;
    ent_t q[$];
    int   now = 0;
    bit   m_ovf = 1'b0;
    bit   m_udf = 1'b0;

    function automatic bit m_vis();
        return (q.size() > 0) && (q[0].e + 2 <= now);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit   v;
        bit   wa;
        ent_t w;
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            v  = m_vis();
            wa = wr_en && (q.size() < DEPTH);
            if (clr) begin
                q.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                if (wr_en && q.size() == DEPTH) m_ovf = 1'b1;
                if (rd_en && !v) m_udf = 1'b1;
                if (rd_en && v) void'(q.pop_front());
                if (wa) begin
                    w.d = din;
                    w.e = now + 1;
                    q.push_back(w);
                end
            end
            now++;
        end
    end

    always @(negedge clk) begin
        chk("empty", int'(empty), int'(!m_vis()));
        chk("cnt", int'(cnt), q.size());
        chk("full", int'(full), int'(q.size() == DEPTH));
        chk("almost_full", int'(almost_full), int'(q.size() >= AF));
        chk("almost_empty", int'(almost_empty), int'(q.size() <= AE));
        if (m_vis()) chk("dout", int'(dout), int'(q[0].d));
`ifdef FIFO_FWFT_ERR_EN
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_udf));
`endif
    end

    // Drive one cycle of inputs just after a falling edge and return at the next falling edge.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        wr_en = w;
        din   = d;
        rd_en = r;
        clr   = c;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
        $display("[TB] t=%0t wr=%0d din=0x%02h rd=%0d clr=%0d -> empty=%0d dout=0x%02h cnt=%0d full=%0d",
                 $time, w, d, r, c, empty, dout, cnt, full);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_empty", int'(empty), 1);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_af", int'(almost_full), 0);
        chk("rst_ae", int'(almost_empty), 1);
        chk("rst_dout", int'(dout), 0);
        rst_n = 1'b1;

        // 1: single word latency
        cyc(1, 8'hA5, 0, 0);
        chk("t1_empty_e0", int'(empty), 1);
        chk("t1_cnt_e0", int'(cnt), 1);
        cyc(0, 8'h00, 0, 0);
        chk("t1_empty_e1", int'(empty), 1);
        cyc(0, 8'h00, 0, 0);
        chk("t1_empty_e2", int'(empty), 0);
        chk("t1_dout", int'(dout), 8'hA5);
        chk("t1_cnt", int'(cnt), 1);
        cyc(0, 8'h00, 1, 0);
        chk("t1_pop_empty", int'(empty), 1);
        chk("t1_pop_cnt", int'(cnt), 0);

        // 2: fill to full, dropped writes, drain in order
        for (int i = 0; i < 8; i++) begin
            cyc(1, 8'(i), 0, 0);
            if (i == 5) chk("t2_af_cnt6", int'(almost_full), 0);
            if (i == 6) chk("t2_af_cnt7", int'(almost_full), 1);
        end
        chk("t2_full", int'(full), 1);
        chk("t2_cnt8", int'(cnt), 8);
        cyc(1, 8'hFF, 0, 0);
        chk("t2_drop_cnt", int'(cnt), 8);
`ifdef FIFO_FWFT_ERR_EN
        chk("t2_overflow", int'(overflow), 1);
`endif
        chk("t2_head0", int'(dout), 0);
        cyc(1, 8'hFF, 1, 0);
        chk("t2_droppop_cnt", int'(cnt), 7);
        for (int i = 1; i < 8; i++) begin
            chk("t2_drain", int'(dout), i);
            cyc(0, 8'h00, 1, 0);
        end
        chk("t2_end_empty", int'(empty), 1);
        chk("t2_end_cnt", int'(cnt), 0);

        // 3: streaming write+pop across pointer wrap
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h10 + i), 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        for (int i = 0; i < 20; i++) begin
            chk("t3_stream_dout", int'(dout), 8'h10 + i);
            cyc(1, 8'(8'h14 + i), 1, 0);
            chk("t3_stream_cnt", int'(cnt), 4);
            chk("t3_stream_valid", int'(empty), 0);
        end
        for (int i = 0; i < 4; i++) begin
            chk("t3_tail", int'(dout), 8'h24 + i);
            cyc(0, 8'h00, 1, 0);
        end
        chk("t3_empty", int'(empty), 1);

        // 4: pop while empty
        cyc(0, 8'h00, 1, 0);
        chk("t4_cnt", int'(cnt), 0);
        chk("t4_empty", int'(empty), 1);
`ifdef FIFO_FWFT_ERR_EN
        chk("t4_underflow", int'(underflow), 1);
        cyc(0, 8'h00, 0, 0);
        chk("t4_udf_sticky", int'(underflow), 1);
        cyc(0, 8'h00, 0, 1);
        chk("t4_udf_clr", int'(underflow), 0);
        chk("t4_ovf_clr", int'(overflow), 0);
`endif

        // 5: clr beats simultaneous write and pop
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h30 + i), 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h55, 1, 1);
        chk("t5_cnt", int'(cnt), 0);
        chk("t5_empty", int'(empty), 1);
        chk("t5_full", int'(full), 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        chk("t5_still_empty", int'(empty), 1);

        // 6: asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'h40 + i), 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        chk("t6_pre_dout", int'(dout), 8'h40);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_empty", int'(empty), 1);
        chk("t6_async_cnt", int'(cnt), 0);
        chk("t6_async_dout", int'(dout), 0);
        chk("t6_async_ae", int'(almost_empty), 1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 8'h60, 0, 0);
        cyc(1, 8'h61, 0, 0);
        cyc(0, 8'h00, 0, 0);
        chk("t6_new0", int'(dout), 8'h60);
        cyc(0, 8'h00, 1, 0);
        chk("t6_new1", int'(dout), 8'h61);
        cyc(0, 8'h00, 1, 0);
        chk("t6_end_empty", int'(empty), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
